conv_relu_pool: RTL and testbench

// Consumes the row-major 2N-bit stream produced by convolver (conv_o/valid_conv_o/end_conv_o) and emits an N-bit activation map.

---
 rtl/conv_relu_pool.sv | 128 ++++++++++++
 tb/tb_conv_relu_pool.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_pool.sv
// Requantizes a 2N-bit convolution stream (bias, ReLU, shift, saturate) and
// applies streaming 2x2/stride-2 max pooling using a half-width line buffer.
module conv_relu_pool #(
  parameter logic [13:0] MaxMatrixSize = 14'd16,
  parameter int unsigned N             = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [2*N-1:0]      conv_i,
  input  logic                valid_i,
  input  logic                end_i,
  input  logic [13:0]         out_size_i,
  input  logic [2*N-1:0]      bias_i,
  input  logic [5:0]          shift_i,
  output logic [N-1:0]        pool_o,
  output logic                valid_o,
  output logic                end_o,
  input  logic                assert_on_i
);

  localparam int unsigned Depth = int'(MaxMatrixSize) / 2;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [N-1:0] QMax = {1'b0, {(N-1){1'b1}}};

  logic [13:0]   col_cnt;
  logic [13:0]   row_cnt;

  logic [2*N:0]  sum;
  logic [2*N:0]  shifted;
  logic [N-1:0]  q_next;

  logic [N-1:0]  q1;
  logic          v1;
  logic          e1;
  logic [AW:0]   c1;
  logic          r1_odd;

  logic [N-1:0]  pair;
  logic [N-1:0]  line_buf [Depth];
  logic [N-1:0]  m;
  logic [N-1:0]  lb_rd;
  logic [N-1:0]  win_max;

  // Sum at 2N+1 bits so bias overflow cannot wrap; a set MSB means negative.
  always_comb begin
    sum     = {conv_i[2*N-1], conv_i} + {bias_i[2*N-1], bias_i};
    shifted = '0;
    if (!sum[2*N]) begin
      shifted = sum >> shift_i;
    end
    q_next = (|shifted[2*N:N-1]) ? QMax : shifted[N-1:0];
  end

  // S1: requantized sample plus its map position and end marker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_cnt <= '0;
      row_cnt <= '0;
      v1      <= 1'b0;
      e1      <= 1'b0;
      q1      <= '0;
      c1      <= '0;
      r1_odd  <= 1'b0;
    end else if (en_i) begin
      v1     <= valid_i;
      e1     <= end_i;
      q1     <= q_next;
      c1     <= col_cnt[AW:0];
      r1_odd <= row_cnt[0];
      if (valid_i) begin
        if (col_cnt == out_size_i - 14'd1) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 14'd1;
        end else begin
          col_cnt <= col_cnt + 14'd1;
        end
      end
      // End of map wins over the increment so the next map starts at (0,0).
      if (end_i) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end
    end
  end

  always_comb begin
    m       = (q1 > pair) ? q1 : pair;
    lb_rd   = line_buf[c1[AW:1]];
    win_max = (lb_rd > m) ? lb_rd : m;
  end

  // S2: horizontal pair max, vertical max against the line buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair    <= '0;
      pool_o  <= '0;
      valid_o <= 1'b0;
      end_o   <= 1'b0;
    end else if (en_i) begin
      valid_o <= 1'b0;
      end_o   <= e1;
      if (v1) begin
        if (!c1[0]) begin
          pair <= q1;
        end else if (r1_odd) begin
          pool_o  <= win_max;
          valid_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && v1 && c1[0] && !r1_odd) begin
      line_buf[c1[AW:1]] <= m;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && assert_on_i && valid_i) begin
      assert (out_size_i >= 14'd2 && out_size_i <= MaxMatrixSize);
      assert (shift_i < 6'(2 * N));
      assert (col_cnt < out_size_i);
    end
  end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed self-checking bench for conv_relu_pool: table-driven 2x2 windows
// plus full-map, stall, reset and back-to-back sequences.
module tb_conv_relu_pool;

  localparam int unsigned N = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic signed [2*N-1:0] conv_i;
  logic                 valid_i;
  logic                 end_i;
  logic [13:0]          out_size_i;
  logic signed [2*N-1:0] bias_i;
  logic [5:0]           shift_i;
  logic [N-1:0]         pool_o;
  logic                 valid_o;
  logic                 end_o;
  logic                 assert_on_i;

  conv_relu_pool #(.MaxMatrixSize(14'd16), .N(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .conv_i(conv_i),
    .valid_i(valid_i), .end_i(end_i), .out_size_i(out_size_i),
    .bias_i(bias_i), .shift_i(shift_i), .pool_o(pool_o),
    .valid_o(valid_o), .end_o(end_o), .assert_on_i(assert_on_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit stall  = 1'b0;

  int got_q[$];
  int end_q[$];
  int exp_q[$];
  int exp_end_q[$];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Records outputs on enabled edges; on stalled edges outputs must not move.
  logic       mon_en, mon_rst, prev_ok = 1'b0;
  logic [17:0] prev_out;
  always @(posedge clk_i) begin
    mon_en  = en_i;
    mon_rst = rst_i;
    #1;
    if (!mon_rst) begin
      if (mon_en) begin
        if (valid_o) got_q.push_back(int'(pool_o));
        if (end_o) end_q.push_back(got_q.size());
      end else if (prev_ok) begin
        chk("stall_hold", {pool_o, valid_o, end_o}, prev_out);
      end
    end
    prev_out = {pool_o, valid_o, end_o};
    prev_ok  = 1'b1;
  end

  task automatic send(input int x, input bit last);
    int tries;
    bit taken;
    conv_i  = x;
    valid_i = 1'b1;
    end_i   = last;
    tries   = 0;
    taken   = 1'b0;
    while (!taken && tries < 200) begin
      en_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_i);
      #1;
      taken = en_i;
      tries++;
    end
    if (!taken) chk("send_timeout", 0, 1);
    valid_i = 1'b0;
    end_i   = 1'b0;
  endtask

  task automatic flush();
    en_i    = 1'b1;
    valid_i = 1'b0;
    end_i   = 1'b0;
    repeat (4) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    en_i    = 1'b1;
    valid_i = 1'b0;
    end_i   = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_ends"}, end_q.size(), exp_end_q.size());
    for (int i = 0; i < exp_end_q.size() && i < end_q.size(); i++)
      chk($sformatf("%s_end%0d_pos", tag, i), end_q[i], exp_end_q[i]);
    got_q.delete();
    end_q.delete();
    exp_q.delete();
    exp_end_q.delete();
  endtask

  task automatic map_seq(input int n);
    for (int i = 0; i < n; i++) send(i, i == n - 1);
  endtask

  task automatic expect_w6(input int ends_at);
    int e6[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    foreach (e6[i]) exp_q.push_back(e6[i]);
    exp_end_q.push_back(ends_at);
  endtask

  typedef struct {
    string name;
    int    bias;
    int    shift;
    int    in0, in1, in2, in3;
    int    exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{"relu_b0",   0,  0, -5, -1, -9, -2, 0};
    vt[1] = '{"relu_b10", 10,  0, -5, -1, -9, -2, 9};
    vt[2] = '{"sat",       0,  0, 1 << 20, 1 << 20, 1 << 20, 1 << 20, 32767};
    vt[3] = '{"shift4",    0,  4, 'h107, 'h107, 'h107, 'h107, 16};

    assert_on_i = 1'b1;
    out_size_i  = 14'd6;
    bias_i      = '0;
    shift_i     = '0;
    conv_i      = '0;
    do_reset();
    chk("reset_pool", pool_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_end", end_o, 0);

    // W=6 full map
    map_seq(36);
    flush();
    expect_w6(9);
    compare_run("w6");

    // W=5: last column and last row dropped
    out_size_i = 14'd5;
    map_seq(25);
    flush();
    exp_q = '{6, 8, 16, 18};
    exp_end_q.push_back(4);
    compare_run("w5");

    out_size_i = 14'd2;
    for (int k = 0; k < 4; k++) begin
      bias_i  = vt[k].bias;
      shift_i = 6'(vt[k].shift);
      send(vt[k].in0, 1'b0);
      send(vt[k].in1, 1'b0);
      send(vt[k].in2, 1'b0);
      send(vt[k].in3, 1'b1);
      flush();
      exp_q.push_back(vt[k].exp);
      exp_end_q.push_back(1);
      compare_run(vt[k].name);
    end
    bias_i  = '0;
    shift_i = '0;

    // W=6 with random stalls
    out_size_i = 14'd6;
    stall = 1'b1;
    map_seq(36);
    stall = 1'b0;
    flush();
    expect_w6(9);
    compare_run("stall");

    // Reset after input 14, then replay the full map
    for (int i = 0; i < 15; i++) send(i, 1'b0);
    do_reset();
    chk("midrst_pool", pool_o, 0);
    chk("midrst_valid", valid_o, 0);
    got_q.delete();
    end_q.delete();
    map_seq(36);
    flush();
    expect_w6(9);
    compare_run("midrst");

    // Two maps with no gap
    map_seq(36);
    map_seq(36);
    flush();
    expect_w6(9);
    expect_w6(18);
    exp_end_q.delete();
    exp_end_q.push_back(9);
    exp_end_q.push_back(18);
    compare_run("b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
